// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter committing two producers' words into a FIFO, retrying on overflow.
module fifo_wr_arb #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] din1,
  output logic                  gnt0,
  output logic                  gnt1,
  input  logic                  fifo_full,
  input  logic                  fifo_wr_ack,
  input  logic                  fifo_overflow,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_din,
  output logic [CNT_WIDTH-1:0]  retry_cnt,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, WRITE, RESP, HOLD} state_t;
  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  sel;
  assign sel = (req0 & req1) ? ~last_q : req1;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    din_d   = din_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if ((req0 | req1) && !fifo_full) begin
        state_d = WRITE;
        owner_d = sel;
        din_d   = sel ? din1 : din0;
      end
      WRITE: state_d = RESP;
      // overflow and a missing ack are treated alike; ack wins when both are seen
      RESP: if (fifo_wr_ack) begin
        state_d = IDLE;
        last_d  = owner_q;
      end else begin
        state_d = HOLD;
        cnt_d   = &cnt_q ? cnt_q : cnt_q + 1'b1;
      end
      HOLD: state_d = fifo_full ? HOLD : WRITE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      din_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
    end
  end
  assign fifo_wr_en = state_q == WRITE;
  assign fifo_din   = din_q;
  assign retry_cnt  = cnt_q;
  assign busy       = state_q != IDLE;
  assign gnt0       = state_q == RESP && fifo_wr_ack && !owner_q;
  assign gnt1       = state_q == RESP && fifo_wr_ack && owner_q;
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed checks of arbitration, retry, saturation and reset behaviour.
module tb_fifo_wr_arb;
  logic        clk = 1'b0;
  logic        rst_n, req0, req1, fifo_full, fifo_wr_ack, fifo_overflow;
  logic [15:0] din0, din1, fifo_din;
  logic        gnt0, gnt1, fifo_wr_en, busy;
  logic [7:0]  retry_cnt;
  int          n_cmp = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  fifo_wr_arb dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .fifo_full(fifo_full), .fifo_wr_ack(fifo_wr_ack),
    .fifo_overflow(fifo_overflow), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .retry_cnt(retry_cnt), .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_wren"}, fifo_wr_en, 0);
    check({tag, "_din"}, fifo_din, 0);
    check({tag, "_retry"}, retry_cnt, 0);
    check({tag, "_gnt"}, {gnt1, gnt0}, 0);
  endtask
  initial begin
    rst_n = 0; req0 = 0; req1 = 0; din0 = 0; din1 = 0;
    fifo_full = 0; fifo_wr_ack = 0; fifo_overflow = 0;
    #2;
    check_idle_zero("reset");
    cyc();
    rst_n = 1;
    // single request
    req0 = 1; din0 = 16'hA5A5;
    cyc();
    check("single_wren", fifo_wr_en, 1);
    check("single_din", fifo_din, 16'hA5A5);
    check("single_busy", busy, 1);
    cyc();
    fifo_wr_ack = 1; #1;
    check("single_wren_resp", fifo_wr_en, 0);
    check("single_gnt", {gnt1, gnt0}, 2'b01);
    cyc();
    req0 = 0; fifo_wr_ack = 0; #1;
    check("single_idle", {busy, gnt1, gnt0}, 0);
    // tie after reset
    rst_n = 0; cyc(); rst_n = 1;
    req0 = 1; req1 = 1; din0 = 16'h1111; din1 = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("tie_wren", fifo_wr_en, 1);
      check("tie_din", fifo_din, (i % 2) ? 16'h2222 : 16'h1111);
      cyc();
      fifo_wr_ack = 1; #1;
      check("tie_gnt", {gnt1, gnt0}, (i % 2) ? 2'b10 : 2'b01);
      cyc();
      fifo_wr_ack = 0; #1;
      check("tie_gap", {gnt1, gnt0, fifo_wr_en}, 0);
    end
    req0 = 0; req1 = 0;
    // overflow retry
    req0 = 1; din0 = 16'hBEEF;
    cyc();
    check("ovf_din", fifo_din, 16'hBEEF);
    cyc();
    fifo_overflow = 1; fifo_full = 1; #1;
    check("ovf_nogrant", {gnt1, gnt0}, 0);
    cyc();
    fifo_overflow = 0;
    check("ovf_retry", retry_cnt, 1);
    check("ovf_busy", busy, 1);
    check("ovf_wren", fifo_wr_en, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("ovf_hold", {busy, fifo_wr_en}, 2'b10);
    end
    fifo_full = 0;
    cyc();
    check("ovf_rewrite", fifo_wr_en, 1);
    check("ovf_redin", fifo_din, 16'hBEEF);
    cyc();
    fifo_wr_ack = 1; #1;
    check("ovf_gnt", {gnt1, gnt0}, 2'b01);
    check("ovf_retry_kept", retry_cnt, 1);
    cyc();
    req0 = 0; fifo_wr_ack = 0;
    // full while idle
    fifo_full = 1; req1 = 1; din1 = 16'hCAFE;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("full_idle", {busy, fifo_wr_en}, 0);
    end
    fifo_full = 0;
    cyc();
    check("full_din", fifo_din, 16'hCAFE);
    cyc();
    fifo_wr_ack = 1; #1;
    check("full_gnt", {gnt1, gnt0}, 2'b10);
    cyc();
    req1 = 0; fifo_wr_ack = 0;
    // retry counter saturation
    req0 = 1; din0 = 16'h0F0F;
    cyc();
    for (int i = 0; i < 260; i++) begin
      cyc();
      fifo_overflow = 1;
      cyc();
      fifo_overflow = 0;
      if (i == 252) check("sat_fe", retry_cnt, 8'hFE);
      cyc();
    end
    check("sat_ff", retry_cnt, 8'hFF);
    cyc();
    fifo_wr_ack = 1; #1;
    check("sat_gnt", {gnt1, gnt0}, 2'b01);
    cyc();
    req0 = 0; fifo_wr_ack = 0;
    // reset during hold
    req1 = 1; din1 = 16'h1234;
    cyc();
    cyc();
    fifo_overflow = 1; fifo_full = 1;
    cyc();
    fifo_overflow = 0;
    check("rsthold_busy", busy, 1);
    rst_n = 0; #1;
    check_idle_zero("rsthold");
    fifo_full = 0;
    cyc();
    rst_n = 1;
    cyc();
    check("rsthold_rewrite", fifo_wr_en, 1);
    check("rsthold_din", fifo_din, 16'h1234);
    cyc();
    fifo_wr_ack = 1; #1;
    check("rsthold_gnt", {gnt1, gnt0}, 2'b10);
    cyc();
    req1 = 0; fifo_wr_ack = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
